// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the decode from MIPS R-type funct field to muldiv op.
package muldiv_pkg;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULU = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_DIVU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdState_e;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  function automatic logic [1:0] mdOpFromFunct(input logic [5:0] funct);
    case (funct)
      FN_MULT:  return MD_MUL;
      FN_MULTU: return MD_MULU;
      FN_DIV:   return MD_DIV;
      FN_DIVU:  return MD_DIVU;
      default:  return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply on {hi, lo}, or
// restoring shift-subtract divide on {remainder, quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 divMode,
  input  logic [2*WIDTH-1:0]   accIn,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   accOut
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
    shifted = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    accOut  = {sum, accIn[WIDTH-1:1]};
    // Remainder stays below the divisor, so the W-bit slice never truncates.
    if (divMode) begin
      if (diff[WIDTH]) accOut = {shifted[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
      else             accOut = {diff[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle, with a
// shared start/annul/ready handshake and divide-by-zero detection.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dbz_o,
  output mdState_e             dbgState
);

  // Handshake: start_i is sampled only in IDLE; ready_o is a one-cycle pulse in
  // DONE with result_o valid; annul_i returns to IDLE from any state.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdState_e             state, nextState;
  logic [1:0]           opReg;
  logic                 signA, signB;
  logic [WIDTH-1:0]     operand;
  logic [2*WIDTH-1:0]   acc, stepAcc;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   resultReg;
  logic                 dbzReg;

  logic                 inSigned, inDiv, divByZero;
  logic [WIDTH-1:0]     absA, absB;
  logic                 opSigned, opDiv, negQuot, negRem;
  logic [WIDTH-1:0]     quot, rem, quotFix, remFix;
  logic [2*WIDTH-1:0]   prodFix, finalResult;

  assign inSigned  = (op_i == MD_MUL) || (op_i == MD_DIV);
  assign inDiv     = (op_i == MD_DIV) || (op_i == MD_DIVU);
  assign divByZero = inDiv && (b_i == '0);
  assign absA = (inSigned && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign absB = (inSigned && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

  assign opSigned = (opReg == MD_MUL) || (opReg == MD_DIV);
  assign opDiv    = (opReg == MD_DIV) || (opReg == MD_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .divMode (opDiv),
    .accIn   (acc),
    .operand (operand),
    .accOut  (stepAcc)
  );

  // Sign fix applied to the final iteration's output as it is registered.
  always_comb begin
    negQuot     = opSigned && (signA ^ signB);
    negRem      = opSigned && signA;
    quot        = stepAcc[WIDTH-1:0];
    rem         = stepAcc[2*WIDTH-1:WIDTH];
    quotFix     = negQuot ? (~quot + WIDTH'(1)) : quot;
    remFix      = negRem ? (~rem + WIDTH'(1)) : rem;
    prodFix     = negQuot ? (~stepAcc + (2*WIDTH)'(1)) : stepAcc;
    finalResult = opDiv ? {remFix, quotFix} : prodFix;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start_i) nextState = divByZero ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt == LAST) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
    if (annul_i) nextState = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opReg     <= MD_MUL;
      signA     <= 1'b0;
      signB     <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      cnt       <= '0;
      resultReg <= '0;
      dbzReg    <= 1'b0;
    end else if (!annul_i) begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            opReg <= op_i;
            signA <= a_i[WIDTH-1];
            signB <= b_i[WIDTH-1];
            cnt   <= '0;
            if (inDiv) begin
              operand <= absB;
              acc     <= {{WIDTH{1'b0}}, absA};
            end else begin
              operand <= absA;
              acc     <= {{WIDTH{1'b0}}, absB};
            end
            if (divByZero) begin
              resultReg <= {a_i, {WIDTH{1'b1}}};
              dbzReg    <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          acc <= stepAcc;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            resultReg <= finalResult;
            dbzReg    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = resultReg;
  assign dbz_o    = dbzReg;
  assign ready_o  = (state == ST_DONE);
  assign busy_o   = (state != ST_IDLE);
  assign dbgState = state;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32 and WIDTH=8: vector table plus
// hand-written annul, reset and divide-by-zero sequences.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, annul = 1'b0;
  logic [1:0]  op = MD_MUL;
  logic [31:0] a = '0, b = '0;
  logic [63:0] result;
  logic        ready, busy, dbz;
  mdState_e    state;

  logic        start8 = 1'b0, annul8 = 1'b0;
  logic [1:0]  op8 = MD_MUL;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] result8;
  logic        ready8, busy8, dbz8;
  mdState_e    state8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
    .a_i(a), .b_i(b), .result_o(result), .ready_o(ready), .busy_o(busy),
    .dbz_o(dbz), .dbgState(state)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .op_i(op8),
    .a_i(a8), .b_i(b8), .result_o(result8), .ready_o(ready8), .busy_o(busy8),
    .dbz_o(dbz8), .dbgState(state8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds start until ready, then consumes the DONE->IDLE edge.
  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, output logic [63:0] res, output logic d,
                       output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; d = dbz; start = 1'b0;
    @(posedge clk); #1;
    check({name, " ready pulse width"}, 64'(ready), 64'd0);
  endtask

  task automatic runOp8(input string name, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] expRes,
                        input logic expDbz, input int expLat);
    int lat;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ready8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " result"}, 64'(result8), 64'(expRes));
    check({name, " dbz"}, 64'(dbz8), 64'(expDbz));
    check({name, " latency"}, 64'(lat), 64'(expLat));
    start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic        d;
    int          lat;
    logic        sawReady;

    vecs[0]  = '{MD_DIVU, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0, 32};
    vecs[1]  = '{MD_DIV,  32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 32};
    vecs[2]  = '{MD_DIV,  32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 32};
    vecs[3]  = '{MD_MUL,  32'hFFFFFFFF,   32'd2,        64'hFFFFFFFF_FFFFFFFE, 1'b0, 32};
    vecs[4]  = '{MD_MULU, 32'hFFFFFFFF,   32'd2,        64'h00000001_FFFFFFFE, 1'b0, 32};
    vecs[5]  = '{MD_DIVU, 32'd5,          32'd0,        64'h00000005_FFFFFFFF, 1'b1, 0};
    vecs[6]  = '{MD_MULU, 32'd3,          32'd4,        64'h00000000_0000000C, 1'b0, 32};
    vecs[7]  = '{MD_DIV,  32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 32};
    vecs[8]  = '{MD_DIV,  32'hFFFFFFF7,   32'd0,        64'hFFFFFFF7_FFFFFFFF, 1'b1, 0};
    vecs[9]  = '{MD_MUL,  32'hFFFFFFFD,   32'hFFFFFFFB, 64'h00000000_0000000F, 1'b0, 32};
    vecs[10] = '{MD_MULU, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 32};
    vecs[11] = '{MD_DIV,  32'd5,          32'hFFFFFFF9, 64'h00000005_00000000, 1'b0, 32};
    vecs[12] = '{MD_DIVU, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1'b0, 32};
    vecs[13] = '{MD_DIVU, 32'h12345678,   32'h00010000, 64'h00005678_00001234, 1'b0, 32};

    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset dbz", 64'(dbz), 64'd0);
    check("reset state", 64'(state), 64'(ST_IDLE));
    check("reset result8", 64'(result8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      runOp($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, res, d, lat);
      check($sformatf("v%0d result", i), res, vecs[i].res);
      check($sformatf("v%0d dbz", i), 64'(d), 64'(vecs[i].dbz));
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Annul 10 cycles into a divide: no pulse, result keeps last value.
    sawReady = 1'b0;
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    check("annul launch busy", 64'(busy), 64'd1);
    repeat (9) begin
      @(posedge clk); #1;
      if (ready) sawReady = 1'b1;
    end
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("annul busy", 64'(busy), 64'd0);
    check("annul state", 64'(state), 64'(ST_IDLE));
    annul = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) sawReady = 1'b1;
    end
    check("annul no ready", 64'(sawReady), 64'd0);
    check("annul result kept", result, 64'h00005678_00001234);

    runOp("post-annul", MD_DIVU, 32'd100, 32'd7, res, d, lat);
    check("post-annul result", res, 64'h00000002_0000000E);
    check("post-annul latency", 64'(lat), 64'd32);

    // Annul together with start in IDLE launches nothing.
    @(negedge clk);
    op = MD_MULU; a = 32'd9; b = 32'd9; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    check("annul+start busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    check("annul+start still idle", 64'(busy), 64'd0);
    check("annul+start result", result, 64'h00000002_0000000E);

    // Reset mid-BUSY after a divide-by-zero left dbz set.
    runOp("pre-reset dbz", MD_DIVU, 32'd5, 32'd0, res, d, lat);
    check("pre-reset dbz flag", 64'(d), 64'd1);
    check("pre-reset dbz latency", 64'(lat), 64'd0);
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    op8 = MD_DIVU; a8 = 8'd200; b8 = 8'd9; start8 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    check("midrst result", result, 64'd0);
    check("midrst ready", 64'(ready), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst dbz", 64'(dbz), 64'd0);
    check("midrst state", 64'(state), 64'(ST_IDLE));
    check("midrst busy8", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp8("w8 divu 200/9", MD_DIVU, 8'd200, 8'd9, 16'h0216, 1'b0, 8);
    runOp8("w8 div -128/-1", MD_DIV, 8'h80, 8'hFF, 16'h0080, 1'b0, 8);
    runOp8("w8 mul -1*2", MD_MUL, 8'hFF, 8'h02, 16'hFFFE, 1'b0, 8);
    runOp8("w8 divu 7/0", MD_DIVU, 8'd7, 8'd0, 16'h07FF, 1'b1, 0);
    runOp8("w8 mulu 255*255", MD_MULU, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
